lag_sequencer: RTL and testbench

Measurement controller for the lag-tester core. It sequences the video datapath's flash patch against frame boundaries and times the photodiode response on the user port. It runs a programmed number of flash/detect samples per run and accumulates min/max/sum statistics for the on-screen readout. It sits inside `system`, between the video timing generator, the pattern renderer, and `user_in`.

---
 rtl/lag_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_lag_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_sequencer.sv
// Lag-tester measurement controller: sequences the flash patch against frame
// starts, times the debounced photodiode response and accumulates run statistics.
module lag_sequencer #(
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned TIMEOUT       = 10_000_000,
    parameter int unsigned DEBOUNCE      = 4,
    parameter int unsigned SETTLE_FRAMES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vblank,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         num_samples,
    input  logic               sensor,
    output logic               flash,
    output logic               busy,
    output logic               sample_valid,
    output logic               sample_timeout,
    output logic [CNT_W-1:0]   sample_cycles,
    output logic               done,
    output logic [4:0]         valid_count,
    output logic [CNT_W-1:0]   result_min,
    output logic [CNT_W-1:0]   result_max,
    output logic [CNT_W+3:0]   result_sum
);

    localparam int unsigned DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned SET_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam int unsigned SUM_W = CNT_W + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_FLASH,
        S_REPORT
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        sync;
    logic [DB_W-1:0]   db_cnt;
    logic              lit;
    logic              vb_q;
    logic              fs;
    logic [SET_W-1:0]  settle, settle_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [4:0]        idx, idx_nxt, idx_inc;
    logic [4:0]        target, target_nxt;
    logic              flash_nxt, busy_nxt, valid_nxt, timeout_nxt, done_nxt;
    logic [CNT_W-1:0]  sc_nxt, min_nxt, max_nxt;
    logic [4:0]        vcount_nxt;
    logic [SUM_W-1:0]  sum_nxt;

    assign fs      = vb_q & ~vblank;
    assign idx_inc = idx + 5'd1;

    // Sensor synchronizer, debounce filter and vblank edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            db_cnt <= '0;
            lit    <= 1'b0;
            vb_q   <= 1'b0;
        end else begin
            sync <= {sync[0], sensor};
            vb_q <= vblank;
            if (sync[1] == lit) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                lit    <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Next-state and registered-output logic; sample results land with the pulse
    always_comb begin
        state_nxt   = state;
        settle_nxt  = settle;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        target_nxt  = target;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        done_nxt    = 1'b0;
        sc_nxt      = sample_cycles;
        vcount_nxt  = valid_count;
        min_nxt     = result_min;
        max_nxt     = result_max;
        sum_nxt     = result_sum;

        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target_nxt = (num_samples == 4'd0) ? 5'd16 : {1'b0, num_samples};
                        idx_nxt    = '0;
                        settle_nxt = '0;
                        vcount_nxt = '0;
                        sum_nxt    = '0;
                        max_nxt    = '0;
                        min_nxt    = '1;
                        state_nxt  = S_ARM;
                    end
                end
                S_ARM: begin
                    if (fs) begin
                        if (lit) begin
                            settle_nxt = '0;
                        end else if (settle == SET_W'(SETTLE_FRAMES - 1)) begin
                            settle_nxt = '0;
                            cnt_nxt    = '0;
                            state_nxt  = S_FLASH;
                        end else begin
                            settle_nxt = settle + SET_W'(1);
                        end
                    end
                end
                S_FLASH: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (lit || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        if (lit) begin
                            valid_nxt  = 1'b1;
                            sc_nxt     = cnt;
                            vcount_nxt = valid_count + 5'd1;
                            sum_nxt    = result_sum + SUM_W'(cnt);
                            if (cnt < result_min) min_nxt = cnt;
                            if (cnt > result_max) max_nxt = cnt;
                        end else begin
                            timeout_nxt = 1'b1;
                        end
                        idx_nxt   = idx_inc;
                        done_nxt  = (idx_inc == target);
                        state_nxt = S_REPORT;
                    end
                end
                S_REPORT: begin
                    state_nxt = done ? S_IDLE : S_ARM;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        flash_nxt = (state_nxt == S_FLASH);
        busy_nxt  = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            settle         <= '0;
            cnt            <= '0;
            idx            <= '0;
            target         <= '0;
            flash          <= 1'b0;
            busy           <= 1'b0;
            sample_valid   <= 1'b0;
            sample_timeout <= 1'b0;
            done           <= 1'b0;
            sample_cycles  <= '0;
            valid_count    <= '0;
            result_min     <= '1;
            result_max     <= '0;
            result_sum     <= '0;
        end else begin
            state          <= state_nxt;
            settle         <= settle_nxt;
            cnt            <= cnt_nxt;
            idx            <= idx_nxt;
            target         <= target_nxt;
            flash          <= flash_nxt;
            busy           <= busy_nxt;
            sample_valid   <= valid_nxt;
            sample_timeout <= timeout_nxt;
            done           <= done_nxt;
            sample_cycles  <= sc_nxt;
            valid_count    <= vcount_nxt;
            result_min     <= min_nxt;
            result_max     <= max_nxt;
            result_sum     <= sum_nxt;
        end
    end

endmodule

// File: tb/tb_lag_sequencer.sv
// Bench for lag_sequencer: directed runs with literal expectations plus an
// event-level reference model compared against the DUT every cycle.
module tb_lag_sequencer;

    localparam int unsigned CNT_W    = 24;
    localparam int unsigned TIMEOUT  = 1000;
    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned SETTLE   = 3;
    localparam longint      ALL1     = (longint'(1) << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               vblank = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [3:0]         num_samples = 4'd0;
    logic               sensor = 1'b0;
    logic               flash, busy, sample_valid, sample_timeout, done;
    logic [CNT_W-1:0]   sample_cycles, result_min, result_max;
    logic [4:0]         valid_count;
    logic [CNT_W+3:0]   result_sum;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    lag_sequencer #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DEBOUNCE(DEBOUNCE), .SETTLE_FRAMES(SETTLE)
    ) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .start(start), .abort(abort),
        .num_samples(num_samples), .sensor(sensor), .flash(flash), .busy(busy),
        .sample_valid(sample_valid), .sample_timeout(sample_timeout),
        .sample_cycles(sample_cycles), .done(done), .valid_count(valid_count),
        .result_min(result_min), .result_max(result_max), .result_sum(result_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Free-running video timing: 40-cycle frames, vblank low edge = frame start
    bit frames_on = 1'b0;
    int fs_count = 0;
    int fphase = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (frames_on) begin
                fphase = (fphase + 1) % 40;
                if (fphase == 0) vblank = 1'b1;
                else if (fphase == 8) begin
                    vblank = 1'b0;
                    fs_count++;
                end
            end else begin
                vblank = 1'b0;
            end
        end
    end

    // Reference model: lit is "last DEBOUNCE sensor samples, two edges old, agree";
    // latency is elapsed cycles since flash start; stats from a list of latencies.
    typedef enum int {M_IDLE, M_ARM, M_FLASH, M_REPORT} mphase_t;
    mphase_t ph = M_IDLE;
    bit      ready = 1'b0;
    bit      lit_m = 1'b0, vbp_m = 1'b0, last_m = 1'b0;
    bit      hist[$];
    longint  lat_q[$];
    longint  cyc = 0, flash_t0 = 0, age;
    int      settle_m = 0, tgt_m = 1, idx_m = 0;
    bit      m_fs, m_lit, m_eq;
    bit      e_flash, e_busy, e_sv, e_st, e_done;
    longint  e_sc = 0, e_cnt, e_min, e_max, e_sum;

    always @(posedge clk) begin
        cyc++;
        m_lit = lit_m;
        m_fs  = vbp_m && !vblank;
        e_sv = 1'b0; e_st = 1'b0; e_done = 1'b0;
        if (reset) begin
            ph = M_IDLE; settle_m = 0; idx_m = 0; tgt_m = 1;
            lat_q.delete(); e_sc = 0; lit_m = 1'b0; vbp_m = 1'b0;
            hist.delete();
            for (int i = 0; i < int'(DEBOUNCE) + 2; i++) hist.push_back(1'b0);
            ready = 1'b1;
        end else begin
            if (abort) ph = M_IDLE;
            else case (ph)
                M_IDLE: if (start) begin
                    tgt_m = (num_samples == 4'd0) ? 16 : int'(num_samples);
                    idx_m = 0; settle_m = 0; lat_q.delete(); ph = M_ARM;
                end
                M_ARM: if (m_fs) begin
                    if (m_lit) settle_m = 0;
                    else if (settle_m + 1 >= int'(SETTLE)) begin
                        settle_m = 0; flash_t0 = cyc + 1; ph = M_FLASH;
                    end else settle_m++;
                end
                M_FLASH: begin
                    age = cyc - flash_t0;
                    if (m_lit) begin
                        e_sv = 1'b1; e_sc = age; lat_q.push_back(age);
                    end else if (age == longint'(TIMEOUT) - 1) e_st = 1'b1;
                    if (e_sv || e_st) begin
                        idx_m++; e_done = (idx_m == tgt_m); last_m = e_done; ph = M_REPORT;
                    end
                end
                M_REPORT: ph = last_m ? M_IDLE : M_ARM;
                default: ph = M_IDLE;
            endcase
            vbp_m = vblank;
            hist.push_back(sensor);
            void'(hist.pop_front());
            m_eq = 1'b1;
            for (int i = 0; i < int'(DEBOUNCE); i++) if (hist[i] != hist[0]) m_eq = 1'b0;
            if (m_eq) lit_m = hist[0];
        end
        e_flash = (ph == M_FLASH);
        e_busy  = (ph != M_IDLE);
        e_cnt = lat_q.size(); e_min = ALL1; e_max = 0; e_sum = 0;
        foreach (lat_q[i]) begin
            if (lat_q[i] < e_min) e_min = lat_q[i];
            if (lat_q[i] > e_max) e_max = lat_q[i];
            e_sum += lat_q[i];
        end
    end

    // Per-cycle compare; stats are checked outside pulse cycles
    always @(negedge clk) begin
        if (ready) begin
            check("m_flash", flash, e_flash);
            check("m_busy", busy, e_busy);
            check("m_sample_valid", sample_valid, e_sv);
            check("m_sample_timeout", sample_timeout, e_st);
            check("m_done", done, e_done);
            check("m_sample_cycles", sample_cycles, e_sc);
            if (!e_sv && !e_st) begin
                check("m_valid_count", valid_count, e_cnt);
                check("m_result_min", result_min, e_min);
                check("m_result_max", result_max, e_max);
                check("m_result_sum", result_sum, e_sum);
            end
        end
    end

    task automatic pulse_start(input logic [3:0] n);
        num_samples = n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_flash(input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (flash) begin ok = 1'b1; break; end
            tick(1);
        end
        check("flash_rise", ok, 1'b1);
    endtask

    // Called in FLASH cycle 0: raise the sensor in cycle k and await the result
    task automatic respond(input int k, output logic [CNT_W-1:0] sc, output bit dn);
        bit ok = 1'b0;
        tick(k);
        sensor = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (sample_valid) begin ok = 1'b1; break; end
        end
        check("valid_pulse", ok, 1'b1);
        sc = sample_cycles;
        dn = done;
        sensor = 1'b0;
    endtask

    initial begin
        logic [CNT_W-1:0] sc;
        bit dn, ok, seen;
        int t, base, nsamp;

        tick(3);
        check("rst_flash", flash, 0);
        check("rst_busy", busy, 0);
        check("rst_min", result_min, ALL1);
        check("rst_count", valid_count, 0);
        check("rst_sum", result_sum, 0);
        reset = 1'b0;
        frames_on = 1'b1;
        tick(2);

        // Basic single sample, response from FLASH cycle 100
        pulse_start(4'd1);
        wait_flash(400);
        respond(100, sc, dn);
        check("basic_cycles", sc, 106);
        check("basic_done", dn, 1);
        tick(1);
        check("basic_count", valid_count, 1);
        check("basic_min", result_min, 106);
        check("basic_max", result_max, 106);
        check("basic_sum", result_sum, 106);
        check("basic_busy", busy, 0);

        // Three-sample statistics
        pulse_start(4'd3);
        wait_flash(400); respond(10, sc, dn); check("stat_s0", sc, 16); check("stat_d0", dn, 0);
        wait_flash(400); respond(50, sc, dn); check("stat_s1", sc, 56); check("stat_d1", dn, 0);
        wait_flash(400); respond(30, sc, dn); check("stat_s2", sc, 36); check("stat_d2", dn, 1);
        tick(1);
        check("stat_min", result_min, 16);
        check("stat_max", result_max, 56);
        check("stat_sum", result_sum, 108);
        check("stat_count", valid_count, 3);

        // Timeout with the sensor dark
        pulse_start(4'd1);
        wait_flash(400);
        t = 0; ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            tick(1); t++;
            if (sample_timeout) begin ok = 1'b1; break; end
        end
        check("to_seen", ok, 1);
        check("to_delay", t, 1000);
        check("to_done", done, 1);
        tick(1);
        check("to_count", valid_count, 0);
        check("to_min", result_min, ALL1);

        // Settle rule with lit sensor, then release plus a short glitch
        sensor = 1'b1;
        tick(10);
        pulse_start(4'd1);
        base = fs_count;
        for (int i = 0; i < 300 && fs_count < base + 5; i++) tick(1);
        check("settle_held", flash, 0);
        sensor = 1'b0;
        base = fs_count;
        for (int i = 0; i < 60 && fs_count < base + 1; i++) tick(1);
        tick(5);
        sensor = 1'b1;
        tick(2);
        sensor = 1'b0;
        wait_flash(300);
        check("settle_frames", fs_count - base, 3);
        respond(20, sc, dn);
        check("settle_cycles", sc, 26);
        tick(3);

        // Start while busy is ignored
        pulse_start(4'd2);
        tick(5);
        pulse_start(4'd5);
        wait_flash(400); respond(7, sc, dn); check("busy_start_d0", dn, 0);
        wait_flash(400); respond(7, sc, dn); check("busy_start_d1", dn, 1);
        tick(3);

        // Abort mid-FLASH
        pulse_start(4'd2);
        wait_flash(400);
        tick(10);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_flash", flash, 0);
        check("abort_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) seen = 1'b1;
            tick(1);
        end
        check("abort_no_done", seen, 0);

        // Reset mid-run
        pulse_start(4'd3);
        wait_flash(400);
        tick(5);
        reset = 1'b1;
        tick(1);
        check("mrst_flash", flash, 0);
        check("mrst_busy", busy, 0);
        check("mrst_cycles", sample_cycles, 0);
        check("mrst_min", result_min, ALL1);
        check("mrst_max", result_max, 0);
        check("mrst_sum", result_sum, 0);
        check("mrst_count", valid_count, 0);
        reset = 1'b0;
        tick(3);

        // num_samples = 0 runs 16 samples
        pulse_start(4'd0);
        nsamp = 0; dn = 1'b0;
        for (int i = 0; i < 20 && !dn; i++) begin
            wait_flash(400);
            respond(5, sc, dn);
            nsamp++;
        end
        check("n16_samples", nsamp, 16);
        tick(1);
        check("n16_count", valid_count, 16);
        check("n16_sum", result_sum, 176);
        check("n16_min", result_min, 11);
        check("n16_max", result_max, 11);

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
